// File: rtl/pipe_ingress_fifo_pkg.sv
// Shared sizing helpers for the pipeline ingress FIFO.
// Widths are derived from DEPTH at elaboration via these constant functions.
package pipe_ingress_fifo_pkg;

  localparam int W_DEFAULT     = 32;
  localparam int DEPTH_DEFAULT = 4;

  // Occupancy must be able to represent DEPTH itself, hence DEPTH+1 codes.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Explicit compare against depth-1 so non-power-of-2 depths wrap correctly.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/pipe_ingress_fifo.sv
// Ingress FIFO feeding the stall pipeline head: unthrottled producer in,
// registered valid/data out, pop only on pipeline accept.
module pipe_ingress_fifo
  import pipe_ingress_fifo_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_vld,
  input  logic [W-1:0]                  push_data,
  output logic                          push_full_r,
  output logic                          push_ovf_r,
  output logic [cnt_width(DEPTH)-1:0]   count_r,
  output logic [W-1:0]                  out_r,
  output logic                          out_vld_r,
  input  logic                          out_accept
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int PTR_W = ptr_width(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Handshake: a word transfers downstream on any edge where out_vld_r and
  // out_accept are both high; out_accept is ignored while out_vld_r is low,
  // and out_r/out_vld_r hold stable while out_vld_r=1 and out_accept=0.
  // The producer side has no backpressure: a push while push_full_r is high
  // is dropped and recorded in the sticky push_ovf_r.

  logic [W-1:0] mem [DEPTH];
  ptr_t         wr_ptr;
  ptr_t         rd_ptr;
  ptr_t         wr_ptr_nxt;
  ptr_t         rd_ptr_nxt;
  logic         pop;
  logic         push_ok;
  logic         push_drop;
  cnt_t         count_nxt;

  always_comb begin
    pop        = out_vld_r & out_accept;
    push_ok    = push_vld & ~push_full_r;
    push_drop  = push_vld & push_full_r;
    wr_ptr_nxt = ptr_t'(ptr_inc(int'(wr_ptr), DEPTH));
    rd_ptr_nxt = ptr_t'(ptr_inc(int'(rd_ptr), DEPTH));
    count_nxt  = count_r;
    case ({push_ok, pop})
      2'b10:   count_nxt = count_r + cnt_t'(1);
      2'b01:   count_nxt = count_r - cnt_t'(1);
      default: count_nxt = count_r;
    endcase
  end

  // Storage keeps every live entry, including the one mirrored in out_r.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_r     <= '0;
      out_vld_r   <= 1'b0;
      push_full_r <= 1'b0;
      push_ovf_r  <= 1'b0;
      out_r       <= '0;
    end else begin
      count_r     <= count_nxt;
      out_vld_r   <= (count_nxt != cnt_t'(0));
      push_full_r <= (count_nxt == cnt_t'(DEPTH));
      if (push_drop) begin
        push_ovf_r <= 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr_nxt;
      end
      // Head register: next-oldest word after a pop, or the incoming word
      // when the FIFO is (or is about to be) otherwise empty.
      if (pop) begin
        rd_ptr <= rd_ptr_nxt;
        if (count_r >= cnt_t'(2)) begin
          out_r <= mem[rd_ptr_nxt];
        end else if (push_ok) begin
          out_r <= push_data;
        end
      end else if (count_r == cnt_t'(0) && push_ok) begin
        out_r <= push_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ingress_fifo.sv
// Self-checking bench for pipe_ingress_fifo: directed vectors on DEPTH=4,
// randomized queue-model comparison on DEPTH=3.
module tb_pipe_ingress_fifo;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          push_vld;
  logic [W-1:0]  push_data;
  logic          out_accept;

  logic          full4, ovf4, vld4;
  logic [2:0]    cnt4;
  logic [W-1:0]  out4;
  logic          full3, ovf3, vld3;
  logic [1:0]    cnt3;
  logic [W-1:0]  out3;

  int tests_run  = 0;
  int tests_fail = 0;
  bit inv_on     = 1'b0;

  pipe_ingress_fifo #(.W(W), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .push_vld(push_vld), .push_data(push_data),
    .push_full_r(full4), .push_ovf_r(ovf4), .count_r(cnt4),
    .out_r(out4), .out_vld_r(vld4), .out_accept(out_accept)
  );

  pipe_ingress_fifo #(.W(W), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .push_vld(push_vld), .push_data(push_data),
    .push_full_r(full3), .push_ovf_r(ovf3), .count_r(cnt3),
    .out_r(out3), .out_vld_r(vld3), .out_accept(out_accept)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // comparison helper
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply inputs, let one rising edge pass, return 1 time unit after it
  task automatic cyc(input logic pv, input logic [W-1:0] pd, input logic acc, input logic r);
    push_vld   = pv;
    push_data  = pd;
    out_accept = acc;
    rst        = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input int e_cnt, input logic e_vld,
                      input logic e_full, input logic e_ovf);
    chk({tag, ".count"}, 32'(cnt4), 32'(e_cnt));
    chk({tag, ".vld"},   32'(vld4), 32'(e_vld));
    chk({tag, ".full"},  32'(full4), 32'(e_full));
    chk({tag, ".ovf"},   32'(ovf4), 32'(e_ovf));
  endtask

  // invariants on both instances, sampled on the falling edge
  always @(negedge clk) begin
    if (inv_on) begin
      chk("inv4.cnt_le_depth", 32'(cnt4 <= 3'd4), 32'd1);
      chk("inv4.vld_eq_nz",    32'(vld4), 32'(cnt4 != 3'd0));
      chk("inv4.full_eq_max",  32'(full4), 32'(cnt4 == 3'd4));
      chk("inv3.cnt_le_depth", 32'(cnt3 <= 2'd3), 32'd1);
      chk("inv3.vld_eq_nz",    32'(vld3), 32'(cnt3 != 2'd0));
      chk("inv3.full_eq_max",  32'(full3), 32'(cnt3 == 2'd3));
    end
  end

  typedef struct {
    logic        pv;
    logic [31:0] pd;
    logic        acc;
    int          e_cnt;
    logic        e_vld;
    logic        chk_out;
    logic [31:0] e_out;
    logic        e_full;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic pv, input logic [31:0] pd, input logic acc, input int e_cnt,
                     input logic e_vld, input logic chk_out, input logic [31:0] e_out,
                     input logic e_full, input logic e_ovf);
    vec_t v;
    v.pv = pv; v.pd = pd; v.acc = acc; v.e_cnt = e_cnt; v.e_vld = e_vld;
    v.chk_out = chk_out; v.e_out = e_out; v.e_full = e_full; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endtask

  // scoreboard for the random phase
  logic [W-1:0] exp_q[$];
  logic         m_ovf;

  initial begin
    push_vld = 1'b0; push_data = '0; out_accept = 1'b0; rst = 1'b1;

    // vector table (DEPTH=4): pv, pd, acc | count, vld, chk_out, out, full, ovf
    // single word, 1-cycle latency then drained
    add(1'b1, 32'hA,  1'b1, 1, 1'b1, 1'b1, 32'hA,  1'b0, 1'b0);
    add(1'b0, 32'h0,  1'b1, 0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
    // fill with accept low, overflow on fifth, then drain in order
    add(1'b1, 32'h1,  1'b0, 1, 1'b1, 1'b1, 32'h1,  1'b0, 1'b0);
    add(1'b1, 32'h2,  1'b0, 2, 1'b1, 1'b1, 32'h1,  1'b0, 1'b0);
    add(1'b1, 32'h3,  1'b0, 3, 1'b1, 1'b1, 32'h1,  1'b0, 1'b0);
    add(1'b1, 32'h4,  1'b0, 4, 1'b1, 1'b1, 32'h1,  1'b1, 1'b0);
    add(1'b1, 32'h5,  1'b0, 4, 1'b1, 1'b1, 32'h1,  1'b1, 1'b1);
    add(1'b0, 32'h0,  1'b1, 3, 1'b1, 1'b1, 32'h2,  1'b0, 1'b1);
    add(1'b0, 32'h0,  1'b1, 2, 1'b1, 1'b1, 32'h3,  1'b0, 1'b1);
    add(1'b0, 32'h0,  1'b1, 1, 1'b1, 1'b1, 32'h4,  1'b0, 1'b1);
    add(1'b0, 32'h0,  1'b1, 0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1);
    // full plus same-cycle pop: registered full still drops the push
    add(1'b1, 32'h11, 1'b0, 1, 1'b1, 1'b1, 32'h11, 1'b0, 1'b1);
    add(1'b1, 32'h12, 1'b0, 2, 1'b1, 1'b1, 32'h11, 1'b0, 1'b1);
    add(1'b1, 32'h13, 1'b0, 3, 1'b1, 1'b1, 32'h11, 1'b0, 1'b1);
    add(1'b1, 32'h14, 1'b0, 4, 1'b1, 1'b1, 32'h11, 1'b1, 1'b1);
    add(1'b1, 32'h15, 1'b1, 3, 1'b1, 1'b1, 32'h12, 1'b0, 1'b1);
    add(1'b0, 32'h0,  1'b1, 2, 1'b1, 1'b1, 32'h13, 1'b0, 1'b1);
    add(1'b0, 32'h0,  1'b1, 1, 1'b1, 1'b1, 32'h14, 1'b0, 1'b1);
    add(1'b0, 32'h0,  1'b1, 0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1);

    // reset state
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 32'hDEAD, 1'b1, 1'b1);
    inv_on = 1'b1;
    chk4("reset", 0, 1'b0, 1'b0, 1'b0);
    chk("reset.out", out4, 32'h0);

    foreach (vecs[i]) begin
      cyc(vecs[i].pv, vecs[i].pd, vecs[i].acc, 1'b0);
      chk4($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_vld, vecs[i].e_full, vecs[i].e_ovf);
      if (vecs[i].chk_out) chk($sformatf("vec%0d.out", i), out4, vecs[i].e_out);
    end

    // streaming: push and accept every cycle holds occupancy at one
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, W'(i + 32'h100), 1'b1, 1'b0);
      chk4($sformatf("stream%0d", i), 1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("stream%0d.out", i), out4, W'(i + 32'h100));
    end

    // reset overrides push/pop with count=2 and overflow set
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, W'(32'h60 + i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk4("pre_rst", 2, 1'b1, 1'b0, 1'b1);
    chk("pre_rst.out", out4, 32'h62);
    cyc(1'b1, 32'h99, 1'b1, 1'b1);
    chk4("mid_rst", 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h7, 1'b0, 1'b0);
    chk4("post_rst", 1, 1'b1, 1'b0, 1'b0);
    chk("post_rst.out", out4, 32'h7);

    // random traffic against a queue model on the DEPTH=3 instance
    cyc(1'b0, '0, 1'b0, 1'b1);
    exp_q.delete();
    m_ovf = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      logic          pv;
      logic          acc;
      logic [W-1:0]  pd;
      bit            had_room;
      pv  = 1'($urandom_range(0, 1));
      acc = 1'($urandom_range(0, 1));
      pd  = W'($urandom);
      had_room = (exp_q.size() < 3);
      if (acc && exp_q.size() != 0) void'(exp_q.pop_front());
      if (pv && had_room) exp_q.push_back(pd);
      if (pv && !had_room) m_ovf = 1'b1;
      cyc(pv, pd, acc, 1'b0);
      chk("rnd.count", 32'(cnt3), 32'(exp_q.size()));
      chk("rnd.vld",   32'(vld3), 32'(exp_q.size() != 0));
      chk("rnd.full",  32'(full3), 32'(exp_q.size() == 3));
      chk("rnd.ovf",   32'(ovf3), 32'(m_ovf));
      if (exp_q.size() != 0) chk("rnd.out", out3, exp_q[0]);
    end

    inv_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ingress_fifo.md
Name: pipe_ingress_fifo

Overview:
Upstream feeder for the linear stall pipeline. It accepts words from a producer that has no backpressure input and buffers them in a DEPTH-entry FIFO. It presents the oldest word to the pipeline head on a registered valid/data pair and pops only on the pipeline's accept. Full, occupancy and sticky overflow status go back to the producer side.

Parameters:
W, 32, data word width in bits.
DEPTH, 4, FIFO capacity in entries, including the head slot; legal range is 2 or more.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; synchronous, active-high.
push_vld  input  1  producer presents push_data this cycle.
push_data  input  W  producer data word.
push_full_r  output  1  registered; FIFO holds DEPTH entries.
push_ovf_r  output  1  registered sticky flag; a push was dropped.
count_r  output  $clog2(DEPTH+1)  registered occupancy.
out_r  output  W  registered head data; drives the pipeline's in.
out_vld_r  output  1  registered head valid; drives the pipeline's in_vld.
out_accept  input  1  pipeline's in_accept.

Behaviour:
- Reset (rst=1 at an edge):
  - count_r=0, out_vld_r=0, push_full_r=0, push_ovf_r=0, pointers=0.
  - out_r is don't-care but is driven to 0.
  - Takes priority over any push or pop in the same cycle; in-flight contents are discarded.
- Pop: occurs when out_vld_r & out_accept. out_accept is ignored when out_vld_r=0.
- Push accepted: push_vld & ~push_full_r. The full test uses the registered flag; a same-cycle pop does not free space for that push.
- Push dropped: push_vld & push_full_r.
  - The word is discarded and push_ovf_r is set.
  - push_ovf_r clears only on rst.
- Ordering: strict FIFO, no reordering.
- Occupancy: count_r(next) = count_r + push_accepted - pop.
  - push_full_r(next) = (count_r(next)==DEPTH).
  - out_vld_r(next) = (count_r(next)!=0).
- Latency: a word pushed into an empty FIFO appears on out_r with out_vld_r=1 on the next cycle. This is 1-cycle latency, no combinational bypass.
- Head update:
  - After a pop with count_r≥2, out_r(next) is the next-oldest word.
  - Pop with count_r==1 plus a simultaneous push: out_r(next) = the pushed word, out_vld_r stays 1.
  - Pop with count_r==1 and no push: out_vld_r(next)=0.
- Hold: while out_vld_r=1 and out_accept=0, out_r and out_vld_r hold stable. This satisfies the pipeline's stall protocol.
- Pointers wrap modulo DEPTH. Non-power-of-2 DEPTH must wrap correctly, with an explicit compare against DEPTH-1.
- Simultaneous push and pop at 0<count_r<DEPTH: count_r is unchanged and throughput is 1 word/cycle.
- Invariants for the bench, as assertions:
  - count_r ≤ DEPTH.
  - out_vld_r == (count_r!=0).
  - push_full_r == (count_r==DEPTH).

Decomposition:
- A shared package holds:
  - the count width constant computed from DEPTH;
  - the pointer width constant;
  - a helper function for modulo-DEPTH pointer increment.
- No sub-module is needed. Storage is a flop array inside the block, with out_r registered from the head slot.
- An optional internal helper is allowed only if it is reused elsewhere: pipe_ingress_store (write port plus registered read-ahead).

Test Plan:
1. Reset, then push 0xA on one cycle with out_accept=1. Next cycle: out_vld_r=1, out_r=0xA, count_r=1. The cycle after: out_vld_r=0, count_r=0.
2. Hold out_accept=0 and push 0x1,0x2,0x3,0x4 on consecutive cycles (DEPTH=4). Required: push_full_r=1 and count_r=4 after the fourth push. A fifth push of 0x5 sets push_ovf_r=1 and leaves count_r=4. Then raise out_accept: the output sequence is 0x1,0x2,0x3,0x4, one per cycle; 0x5 never appears.
3. Fill to count_r=4, then drive push_vld=1 with out_accept=1 on the same cycle. Required: push dropped, push_ovf_r=1, count_r=3 next cycle.
4. Continuous push of an incrementing counter with out_accept=1 every cycle. Required: steady state count_r=1, out_r advances by 1 every cycle, no drops, push_full_r never asserts.
5. Random push_vld and random out_accept, ~50% each, over 10k cycles with DEPTH=3 (non-power-of-2 wrap). Required: the output order matches a scoreboard of accepted pushes, and all invariants hold.
6. With count_r=2 and push_ovf_r=1, assert rst for one cycle while push_vld=1 and out_accept=1. Next cycle: count_r=0, out_vld_r=0, push_ovf_r=0, push_full_r=0. A subsequent push 0x7 appears on out_r one cycle later.
